// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: register offsets, STATUS bit
// positions, word width and a helper that assembles the STATUS word.
package spi_target_pkg;

    localparam int WORD_W = 16;

    // Register offsets relative to BASE_ADDR
    localparam logic [15:0] OFS_DATA   = 16'd0;
    localparam logic [15:0] OFS_STATUS = 16'd1;

    // STATUS bit positions
    localparam int ST_RX_VALID  = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_UNDERRUN  = 3;
    localparam int ST_FRAME_ERR = 4;
    localparam int ST_BUSY      = 5;
    localparam int ST_OCC_LSB   = 8;
    localparam int ST_OCC_W     = 3;

    typedef struct packed {
        logic busy;
        logic frame_err;
        logic underrun;
        logic overrun;
        logic tx_empty;
        logic rx_valid;
    } status_flags_t;

    function automatic logic [WORD_W-1:0] pack_status(input status_flags_t f,
                                                      input logic [ST_OCC_W-1:0] occ);
        logic [WORD_W-1:0] s;
        s = '0;
        s[ST_RX_VALID]  = f.rx_valid;
        s[ST_TX_EMPTY]  = f.tx_empty;
        s[ST_OVERRUN]   = f.overrun;
        s[ST_UNDERRUN]  = f.underrun;
        s[ST_FRAME_ERR] = f.frame_err;
        s[ST_BUSY]      = f.busy;
        s[ST_OCC_LSB +: ST_OCC_W] = occ;
        return s;
    endfunction

endpackage

// File: rtl/spi_target_fifo.sv
// RX FIFO for the SPI target. Only compiled when SPI_TARGET_FIFO_EN is
// defined; otherwise the top uses a single holding register instead.
// A push into a full FIFO is accepted only if a pop happens in the same
// cycle. head reads 0 while empty.
`ifdef SPI_TARGET_FIFO_EN
module spi_target_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`endif

// File: rtl/spi_target.sv
// SPI mode-0 target (16-bit words, MSB first) with a j1 IO register pair:
// DATA at BASE_ADDR (read = RX head and pop, write = TX holding) and
// STATUS at BASE_ADDR+1 (W1C on the error flags).
// Build option: define SPI_TARGET_FIFO_EN to get an RX_DEPTH-entry RX FIFO
// with occupancy in STATUS[10:8]; without it RX is one holding register.
// The TX holding register is consumed at every word start (ssb fall and
// each 16th sck rise); starting a word with it empty sends zeros and sets
// underrun.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h4000,
    parameter int          RX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        ssb,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] io_din
);
    localparam int RX_CNT_W = $clog2(RX_DEPTH) + 1;

    logic [2:0]        sck_s;
    logic [2:0]        ssb_s;
    logic [2:0]        mosi_s;
    logic              sck_rise;
    logic              sck_fall;
    logic              ssb_fall;
    logic              ssb_rise;
    logic              active;
    logic              bit_rise;
    logic              bit_fall;
    logic              word_done;
    logic              tx_load;
    logic [3:0]        bit_cnt;
    logic [WORD_W-2:0] rx_shift;
    logic [WORD_W-1:0] rx_word;
    logic              push;
    logic [WORD_W-1:0] tx_shift;
    logic [WORD_W-1:0] tx_hold;
    logic [WORD_W-1:0] tx_next;
    logic              tx_empty;
    logic              overrun;
    logic              underrun;
    logic              frame_err;
    logic              sel_data;
    logic              sel_stat;
    logic              data_rd;
    logic              data_wr;
    logic              stat_wr;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [WORD_W-1:0] rx_head;
    logic [RX_CNT_W-1:0] rx_count;
    status_flags_t     flags;
    logic [WORD_W-1:0] status;

    // Three-flop synchronizers; idle values match an unselected bus
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s  <= 3'b000;
            ssb_s  <= 3'b111;
            mosi_s <= 3'b000;
        end else begin
            sck_s  <= {sck_s[1:0], sck};
            ssb_s  <= {ssb_s[1:0], ssb};
            mosi_s <= {mosi_s[1:0], mosi};
        end
    end

    assign sck_rise  = sck_s[1] & ~sck_s[2];
    assign sck_fall  = ~sck_s[1] & sck_s[2];
    assign ssb_fall  = ~ssb_s[1] & ssb_s[2];
    assign ssb_rise  = ssb_s[1] & ~ssb_s[2];
    assign active    = ~ssb_s[2];
    assign miso_oe   = active;
    assign bit_rise  = active & sck_rise & ~ssb_rise;
    assign bit_fall  = active & sck_fall & ~ssb_rise;
    assign word_done = bit_rise & (bit_cnt == 4'd15);
    assign tx_load   = ssb_fall | word_done;
    assign tx_next   = tx_empty ? '0 : tx_hold;

    // Bit engine: counter, shift registers, miso and the registered RX push
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_word  <= '0;
            push     <= 1'b0;
            tx_shift <= '0;
            miso     <= 1'b0;
        end else begin
            push <= word_done;
            if (word_done) rx_word <= {rx_shift, mosi_s[2]};
            if (ssb_fall) begin
                // First bit goes straight to miso; the rest waits in tx_shift
                bit_cnt  <= '0;
                tx_shift <= tx_next << 1;
                miso     <= tx_next[WORD_W-1];
            end else if (ssb_rise) begin
                bit_cnt <= '0;
                miso    <= 1'b0;
            end else if (bit_rise) begin
                rx_shift <= {rx_shift[WORD_W-3:0], mosi_s[2]};
                bit_cnt  <= bit_cnt + 4'd1;
                // Unshifted reload: the next fall presents bit 15 of the new word
                if (bit_cnt == 4'd15) tx_shift <= tx_next;
            end else if (bit_fall) begin
                miso     <= tx_shift[WORD_W-1];
                tx_shift <= tx_shift << 1;
            end else if (!active) begin
                miso <= 1'b0;
            end
        end
    end

    assign sel_data = (mem_addr == BASE_ADDR + OFS_DATA);
    assign sel_stat = (mem_addr == BASE_ADDR + OFS_STATUS);
    assign data_rd  = io_rd & sel_data;
    assign data_wr  = io_wr & sel_data;
    assign stat_wr  = io_wr & sel_stat;
    assign rx_pop   = data_rd & ~rx_empty;

    // TX holding register: consumed at each word start, refilled by DATA writes
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_hold  <= '0;
            tx_empty <= 1'b1;
        end else begin
            if (tx_load) tx_empty <= 1'b1;
            if (data_wr) begin
                tx_hold  <= dout;
                tx_empty <= 1'b0;
            end
        end
    end

`ifdef SPI_TARGET_FIFO_EN
    spi_target_fifo #(
        .DEPTH (RX_DEPTH),
        .W     (WORD_W)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rx_pop),
        .wdata (rx_word),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );
`else
    logic [WORD_W-1:0] rx_hold;
    logic              rx_valid_r;

    // Single-entry RX: a push replaces the word only if it is free or being read
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_hold    <= '0;
            rx_valid_r <= 1'b0;
        end else if (push && (!rx_valid_r || rx_pop)) begin
            rx_hold    <= rx_word;
            rx_valid_r <= 1'b1;
        end else if (rx_pop) begin
            rx_valid_r <= 1'b0;
        end
    end

    assign rx_full  = rx_valid_r;
    assign rx_empty = ~rx_valid_r;
    assign rx_head  = rx_valid_r ? rx_hold : '0;
    assign rx_count = '0;
`endif

    // Sticky error flags; a set in the same cycle as its W1C wins
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (push & rx_full & ~rx_pop)
                       | (overrun & ~(stat_wr & dout[ST_OVERRUN]));
            underrun  <= (tx_load & tx_empty)
                       | (underrun & ~(stat_wr & dout[ST_UNDERRUN]));
            frame_err <= (ssb_rise & (bit_cnt != 4'd0))
                       | (frame_err & ~(stat_wr & dout[ST_FRAME_ERR]));
        end
    end

    // STATUS word assembly
    always_comb begin
        flags           = '0;
        flags.rx_valid  = ~rx_empty;
        flags.tx_empty  = tx_empty;
        flags.overrun   = overrun;
        flags.underrun  = underrun;
        flags.frame_err = frame_err;
        flags.busy      = active;
        status          = pack_status(flags, ST_OCC_W'(rx_count));
    end

    // Read mux; zero when neither register is addressed so it can be ORed
    always_comb begin
        io_din = '0;
        if (sel_data)      io_din = rx_head;
        else if (sel_stat) io_din = status;
    end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target. Drives SPI frames at clk/8 and checks
// register reads, miso data and flags against an event-level model
// (word queue plus flag bits). Works with or without SPI_TARGET_FIFO_EN.
module tb_spi_target;
    localparam logic [15:0] BASE = 16'h4000;
`ifdef SPI_TARGET_FIFO_EN
    localparam int CAP     = 4;
    localparam bit FIFO_ON = 1'b1;
`else
    localparam int CAP     = 1;
    localparam bit FIFO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0;
    logic        ssb = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] mem_addr = 16'h0;
    logic [15:0] dout = 16'h0;
    logic [15:0] io_din;

    int errors = 0;
    int checks = 0;

    spi_target #(.BASE_ADDR(BASE), .RX_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .sck(sck), .ssb(ssb), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .io_rd(io_rd), .io_wr(io_wr),
        .mem_addr(mem_addr), .dout(dout), .io_din(io_din)
    );

    always #5 clk = ~clk;

    initial begin
        #20000000;
        $display("FAIL timeout: simulation did not finish (errors=%0d)", errors);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [15:0] m_q[$];
    logic [15:0] m_hold;
    logic [15:0] m_cur;
    bit          m_tx_empty, m_ovr, m_und, m_frm;
    logic [15:0] frame_words[8];

    function automatic void m_reset();
        m_q.delete();
        m_hold = 16'h0; m_cur = 16'h0;
        m_tx_empty = 1'b1; m_ovr = 1'b0; m_und = 1'b0; m_frm = 1'b0;
    endfunction

    // A word starts: take the TX holding value (or zeros if none)
    function automatic void m_start();
        if (m_tx_empty) begin m_cur = 16'h0; m_und = 1'b1; end
        else m_cur = m_hold;
        m_tx_empty = 1'b1;
    endfunction

    function automatic void m_recv(input logic [15:0] w);
        if (m_q.size() >= CAP) m_ovr = 1'b1;
        else m_q.push_back(w);
    endfunction

    function automatic logic [15:0] m_pop();
        logic [15:0] v;
        v = 16'h0;
        if (m_q.size() > 0) v = m_q.pop_front();
        return v;
    endfunction

    function automatic logic [15:0] m_status(input bit busy);
        logic [15:0] s;
        s = 16'h0;
        s[0] = (m_q.size() != 0);
        s[1] = m_tx_empty;
        s[2] = m_ovr;
        s[3] = m_und;
        s[4] = m_frm;
        s[5] = busy;
        if (FIFO_ON) s[10:8] = 3'(m_q.size());
        return s;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic peek(input logic [15:0] a, output logic [15:0] v);
        mem_addr = a; #1; v = io_din; mem_addr = 16'h0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] v);
        mem_addr = a; io_rd = 1'b1; #1; v = io_din;
        tick(1);
        io_rd = 1'b0; mem_addr = 16'h0;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        mem_addr = a; dout = d; io_wr = 1'b1;
        tick(1);
        io_wr = 1'b0; mem_addr = 16'h0; dout = 16'h0;
    endtask

    task automatic chk_data(input string name);
        logic [15:0] v;
        bus_rd(BASE, v);
        chk(name, v, m_pop());
    endtask

    task automatic chk_status(input string name);
        logic [15:0] v;
        bus_rd(BASE + 16'd1, v);
        chk(name, v, m_status(1'b0));
    endtask

    task automatic tx_write(input logic [15:0] d);
        bus_wr(BASE, d);
        m_hold = d; m_tx_empty = 1'b0;
    endtask

    task automatic w1c(input logic [15:0] d);
        bus_wr(BASE + 16'd1, d);
        if (d[2]) m_ovr = 1'b0;
        if (d[3]) m_und = 1'b0;
        if (d[4]) m_frm = 1'b0;
    endtask

    // One ssb frame: nwords full words from frame_words, then an optional
    // partial word of tail bits. mode 1 checks RX-valid latency on the first
    // word; mode 2 reads DATA in the cycle the first word is pushed.
    task automatic spi_frame(input int nwords, input int tail, input int mode);
        logic [15:0] got, exp_tx, v;
        int nb;
        ssb = 1'b0; m_start();
        tick(6);
        chk("miso_oe in frame", 16'(miso_oe), 16'h1);
        for (int w = 0; w < nwords + ((tail > 0) ? 1 : 0); w++) begin
            nb = (w < nwords) ? 16 : tail;
            exp_tx = m_cur; got = 16'h0;
            for (int b = 0; b < nb; b++) begin
                mosi = frame_words[w][15-b];
                tick(4);
                got = {got[14:0], miso};
                sck = 1'b1;
                if (b == 15) begin
                    if (mode == 1 && w == 0) begin
                        tick(3); peek(BASE + 16'd1, v);
                        chk("rx_valid at 3 clk", 16'(v[0]), 16'(m_q.size() != 0));
                        tick(1); peek(BASE + 16'd1, v);
                        chk("rx_valid at 4 clk", 16'(v[0]), 16'h1);
                        m_recv(frame_words[w]);
                    end else if (mode == 2 && w == 0) begin
                        tick(3);
                        mem_addr = BASE; io_rd = 1'b1; #1; v = io_din;
                        chk("data read at push", v, m_pop());
                        tick(1);
                        io_rd = 1'b0; mem_addr = 16'h0;
                        m_recv(frame_words[w]);
                    end else begin
                        tick(4);
                        m_recv(frame_words[w]);
                    end
                    m_start();
                end else begin
                    tick(4);
                end
                sck = 1'b0;
            end
            if (nb == 16) chk("miso word", got, exp_tx);
        end
        tick(4);
        ssb = 1'b1;
        if (tail > 0) m_frm = 1'b1;
        tick(8);
    endtask

    // ---------------- reset-state vector table ----------------
    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[10];

    initial begin
        logic [15:0] v;
        logic        b;

        vecs[0] = '{1'b0, BASE + 16'd1, 16'h0000, 16'h0002};
        vecs[1] = '{1'b0, BASE,         16'h0000, 16'h0000};
        vecs[2] = '{1'b0, BASE + 16'd2, 16'h0000, 16'h0000};
        vecs[3] = '{1'b0, 16'h0000,     16'h0000, 16'h0000};
        vecs[4] = '{1'b1, BASE,         16'h1234, 16'h0000};
        vecs[5] = '{1'b0, BASE + 16'd1, 16'h0000, 16'h0000};
        vecs[6] = '{1'b1, BASE + 16'd1, 16'hFFFF, 16'h0000};
        vecs[7] = '{1'b0, BASE + 16'd1, 16'h0000, 16'h0000};
        vecs[8] = '{1'b1, BASE,         16'h5678, 16'h0000};
        vecs[9] = '{1'b0, BASE,         16'h0000, 16'h0000};

        m_reset();
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("reset miso_oe", 16'(miso_oe), 16'h0);
        chk("reset miso", 16'(miso), 16'h0);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
            else begin
                bus_rd(vecs[i].addr, v);
                chk($sformatf("vec%0d", i), v, vecs[i].exp);
            end
        end
        m_hold = 16'h5678; m_tx_empty = 1'b0;

        // Basic receive with BEEF out, A55A in, latency checked
        tx_write(16'hBEEF);
        frame_words[0] = 16'hA55A;
        spi_frame(1, 0, 1);
        chk_data("receive A55A");
        chk_status("status after receive");
        chk("miso idle", 16'(miso), 16'h0);

        // Three-word burst in one frame
        w1c(16'h001C);
        tx_write(16'h1111);
        frame_words[0] = 16'h0001; frame_words[1] = 16'h0002; frame_words[2] = 16'h0003;
        spi_frame(3, 0, 0);
        chk_status("burst status");
        for (int i = 0; i < 3; i++) chk_data($sformatf("burst read%0d", i));
        chk_status("burst drained");

        // Overrun: one more word than RX can hold, no reads
        w1c(16'h001C);
        for (int i = 0; i < 5; i++) frame_words[i] = 16'h0010 + 16'(i);
        spi_frame(CAP + 1, 0, 0);
        chk_status("overrun status");
        w1c(16'h0004);
        chk_status("overrun cleared");
        for (int i = 0; i <= CAP; i++) chk_data($sformatf("overrun read%0d", i));

        // Frame error after 7 bits, then a word with TX empty
        w1c(16'h001C);
        tx_write(16'hFFFF);
        frame_words[0] = 16'h5A00;
        spi_frame(0, 7, 0);
        chk_status("frame_err status");
        chk_data("no push on frame error");
        w1c(16'h001C);
        chk_status("flags cleared");
        frame_words[0] = 16'h0F0F;
        spi_frame(1, 0, 0);
        chk_status("underrun status");
        chk_data("underrun word received");

        // Fill RX, then pop in the same cycle as the next push
        w1c(16'h001C);
        for (int i = 0; i < CAP; i++) frame_words[i] = 16'hC000 + 16'(i);
        spi_frame(CAP, 0, 0);
        frame_words[0] = 16'hD00D;
        spi_frame(1, 0, 2);
        chk_status("pop+push status");
        for (int i = 0; i < CAP; i++) chk_data($sformatf("pop+push read%0d", i));

        // Reset in the middle of a word (9 bits in)
        tx_write(16'h8001);
        ssb = 1'b0; m_start();
        tick(6);
        for (int i = 0; i < 9; i++) begin
            mosi = 1'($urandom); tick(4); sck = 1'b1; tick(4); sck = 1'b0;
        end
        tick(2);
        reset = 1'b1; ssb = 1'b1; mosi = 1'b0;
        tick(3);
        reset = 1'b0;
        m_reset();
        tick(4);
        chk("post-reset miso_oe", 16'(miso_oe), 16'h0);
        chk_status("post-reset status");
        chk_data("post-reset rx empty");
        tx_write(16'h3C3C);
        frame_words[0] = 16'h9876;
        spi_frame(1, 0, 0);
        chk_data("post-reset receive");

        // Randomized mix of operations against the model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: tx_write(16'($urandom));
                1: begin
                    int nw, tl;
                    nw = $urandom_range(0, 2);
                    tl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
                    if (nw == 0 && tl == 0) nw = 1;
                    for (int k = 0; k < 3; k++) frame_words[k] = 16'($urandom);
                    spi_frame(nw, tl, 0);
                    chk_status("rand frame status");
                end
                2: chk_data("rand data");
                3: chk_status("rand status");
                default: begin
                    w1c(16'($urandom));
                    chk_status("rand w1c");
                end
            endcase
        end
        b = miso;
        chk("final miso idle", 16'(b), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter BASE_ADDR, default 16'h4000: IO address of the DATA register; STATUS is at BASE_ADDR+1.
REQ-002 Parameter RX_DEPTH, default 4: RX FIFO depth, a power of two, used only when the FIFO is compiled in.
REQ-003 Port list (name, direction, width, meaning):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sck  in  1  SPI clock from the external initiator
- ssb  in  1  SPI select, active-low
- mosi  in  1  serial data in
- miso  out  1  serial data out
- miso_oe  out  1  MISO output enable, to drive an SB_IO
- io_rd  in  1  j1 IO read strobe
- io_wr  in  1  j1 IO write strobe
- mem_addr  in  16  j1 IO address
- dout  in  16  j1 write data
- io_din  out  16  read data; 16'd0 when neither register is addressed, so it can be ORed into the top-level read mux

Function
REQ-004 sck, ssb and mosi SHALL each pass through a 3-flop synchronizer before use; sck and ssb edges are detected on the last two stages.
REQ-005 The SPI mode SHALL be mode 0, 16-bit words, MSB first; the sck frequency SHALL be at most clk/8.
REQ-006 On the ssb falling edge: bit counter := 0; tx shift register := TX holding register; miso := bit 15 of that value.
REQ-007 TX holding empty at a word start: shift register := 16'h0000 and the underrun flag is set.
REQ-008 On each sck rising edge with ssb low: shift in mosi (LSB side) and increment the 4-bit counter.
REQ-009 On each sck falling edge with ssb low: miso := next tx shift bit.
REQ-010 On the 16th rising edge:
- the received word is pushed to RX and the counter wraps to 0
- the tx shift register reloads from the TX holding register, which becomes empty
- a continuous multi-word burst therefore needs no ssb toggle.
REQ-011 RX valid SHALL be visible in STATUS exactly 4 clk after the 16th sck rising edge at the pin (3 sync stages + 1 register).
REQ-012 ssb rising with counter != 0: the partial word is discarded, the counter clears, and the frame_err flag is set; with counter == 0 there is no flag.
REQ-013 miso_oe SHALL equal the inverse of synchronized ssb; while ssb is high, miso holds 0.
REQ-014 DATA read (io_rd & DATA address):
- io_din returns the RX head combinationally in the same cycle
- RX pops at the end of that cycle
- a read when RX is empty returns 16'h0000, pops nothing, and sets no flag.
REQ-015 DATA write (io_wr & DATA address): TX holding := dout, TX empty := 0; a write while TX is full overwrites the held value.
REQ-016 STATUS read layout:
- [0] rx_valid, [1] tx_empty, [2] overrun, [3] underrun, [4] frame_err, [5] busy (synchronized ssb low)
- [10:8] RX occupancy, which reads 0 when the FIFO is compiled out
- all other bits 0.
REQ-017 STATUS write SHALL be write-1-to-clear for bits [4:2]; other bits are ignored.
REQ-018 RX push while RX is full: the word is dropped, overrun is set, and stored data is unchanged.
REQ-019 RX push and DATA pop in the same cycle: both take effect; occupancy is unchanged, and a full RX is not overrun.
REQ-020 If a set condition and a W1C of the same flag coincide, the set wins.

Reset
REQ-021 When reset is high at a clk edge, the block SHALL load:
- miso = 0, miso_oe = 0
- counter = 0, shift registers = 0
- TX holding = 0, tx_empty = 1
- RX empty, all flags = 0
- synchronizer stages = idle (sck = 0, ssb = 1, mosi = 0).
REQ-022 Reset asserted mid-word SHALL abandon the word with no push and no flags set; after reset, the block waits for a fresh ssb falling edge.

Configuration
REQ-023 SPI_TARGET_FIFO_EN defined: RX is a RX_DEPTH-entry FIFO with occupancy in STATUS[10:8].
REQ-024 SPI_TARGET_FIFO_EN undefined: RX is a single holding register (full == rx_valid) and STATUS[10:8] reads 0; all other behaviour is identical.

Structure
REQ-025 A shared package SHALL hold the register offsets (DATA = 0, STATUS = 1), the STATUS bit positions, and the word width 16.
REQ-026 The RX FIFO SHALL be a sub-module named spi_target_fifo (push/pop/full/empty/count), instantiated only under SPI_TARGET_FIFO_EN.

Verification
REQ-027 Receive: TX holds 16'hBEEF; the initiator sends 16'hA55A at clk/8 → miso shifts out 16'hBEEF MSB first, DATA reads 16'hA55A, and STATUS[0] rises 4 clk after the last sck rise.
REQ-028 Burst: 3 words 16'h0001, 16'h0002, 16'h0003 in one ssb frame with FIFO on → occupancy 3, then reads in order, then STATUS[0] = 0.
REQ-029 Overrun: FIFO on, 5 words with no reads → 4 stored, overrun = 1, 5th word lost; writing STATUS 16'h0004 clears the flag.
REQ-030 Frame error and underrun: ssb raised after 7 bits → frame_err = 1, no push; a word started with TX empty → miso all 0s, underrun = 1.
REQ-031 Simultaneous events, FIFO off: a DATA read in the same cycle as a push → old word returned, new word held, overrun = 0.
REQ-032 Reset mid-word at bit 9: afterwards all flags = 0, RX empty, miso_oe = 0, and the next full frame is received correctly.
